wb_master_bridge: RTL and testbench

Wishbone classic single-transfer initiator. It drives the same slave port the user-project core exposes (cyc/stb/we/adr/dat/sel in, ack/dat out), from the master side. A simple valid/ready command stream is converted into one Wishbone transaction per command, and the result is returned on a valid/ready response stream. It is used by on-chip test/debug logic (LA- or UART-driven) to reach Wishbone slaves without the management SoC.

---
 rtl/wb_master_bridge.sv | 105 ++++++++++
 tb/tb_wb_master_bridge.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
// Wishbone classic single-transfer initiator: one bus cycle per valid/ready command,
// result returned on a valid/ready response stream, with optional ack timeout.
module wb_master_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic [DATA_W-1:0]   wbm_dat_i,
    input  logic                wbm_ack_i
);
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rdy_q;
    logic             timeout_hit;

    // rdy_q tracks "in IDLE" but stays low for the first cycle out of reset
    assign cmd_ready   = rdy_q && !wb_rst_i;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy_q     <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && rdy_q) begin
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        cnt       <= '0;
                        rdy_q     <= 1'b0;
                        state     <= BUS;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                BUS: begin
                    // ack takes priority over a timeout landing in the same cycle
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (timeout_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rdy_q     <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed + randomized bench for wb_master_bridge (TIMEOUT_CYCLES=8) with a
// transaction-level expectation model derived from ack position and stall length.
module tb_wb_master_bridge;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;
    logic        ack;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    wb_master_bridge #(.TIMEOUT_CYCLES(T), .ADDR_W(32), .DATA_W(32)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o), .wbm_adr_o(adr_o),
        .wbm_dat_o(dat_o), .wbm_sel_o(sel_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ack_at: stb cycle (1-based) in which the slave acks; 0 or >T means it never acks in time
    task automatic do_txn(input string name, input bit we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input int ack_at,
                          input logic [31:0] rdata, input int stall);
        bit          acked;
        int          e_cyc, n, k, lat;
        bit          e_err;
        logic [31:0] e_dat;
        acked = (ack_at >= 1) && (ack_at <= T);
        e_cyc = acked ? ack_at : T;
        e_err = !acked;
        e_dat = (acked && !we) ? rdata : 32'h0;

        rsp_ready = (stall == 0);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk({name, "/accept"}, cmd_ready, 1);
        @(negedge clk);
        lat = 1;
        cmd_valid = 1'b0;
        // scramble the command bus: the bridge must have latched at the handshake
        cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);

        k = 0;
        while (cyc === 1'b1 && k < 40) begin
            k++;
            chk({name, "/stb"}, stb, 1);
            chk({name, "/we"}, we_o, we);
            chk({name, "/adr"}, adr_o, adr);
            chk({name, "/dat_o"}, dat_o, dat);
            chk({name, "/sel"}, sel_o, sel);
            chk({name, "/bus_rsp_valid"}, rsp_valid, 0);
            chk({name, "/bus_cmd_ready"}, cmd_ready, 0);
            ack   = (k == ack_at);
            dat_i = (k == ack_at) ? rdata : $urandom;
            @(negedge clk);
            lat++;
        end
        ack = 1'b0;
        chk({name, "/cyc_cycles"}, k, e_cyc);
        chk({name, "/stb_off"}, stb, 0);
        chk({name, "/rsp_valid"}, rsp_valid, 1);
        chk({name, "/rsp_err"}, rsp_err, e_err);
        chk({name, "/rsp_dat"}, rsp_dat, e_dat);

        // backpressure; late/stray acks are thrown at the bridge meanwhile
        for (int i = 0; i < stall; i++) begin
            ack   = 1'($urandom_range(0, 1));
            dat_i = $urandom;
            @(negedge clk);
            lat++;
            chk({name, "/hold_valid"}, rsp_valid, 1);
            chk({name, "/hold_err"}, rsp_err, e_err);
            chk({name, "/hold_dat"}, rsp_dat, e_dat);
            chk({name, "/hold_cmd_ready"}, cmd_ready, 0);
            chk({name, "/hold_cyc"}, cyc, 0);
        end
        ack = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        lat++;
        chk({name, "/rsp_done"}, rsp_valid, 0);
        chk({name, "/ready_again"}, cmd_ready, 1);
        chk({name, "/latency"}, lat, e_cyc + stall + 2);

        // ack while idle must not produce anything
        ack = 1'b1; dat_i = $urandom;
        @(negedge clk);
        chk({name, "/idle_ack_rsp"}, rsp_valid, 0);
        chk({name, "/idle_ack_cyc"}, cyc, 0);
        ack = 1'b0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        rsp_ready = 1'b0; dat_i = '0; ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst/cmd_ready", cmd_ready, 0);
        chk("rst/cyc", cyc, 0);
        chk("rst/stb", stb, 0);
        chk("rst/we", we_o, 0);
        chk("rst/adr", adr_o, 0);
        chk("rst/dat_o", dat_o, 0);
        chk("rst/sel", sel_o, 0);
        chk("rst/rsp_valid", rsp_valid, 0);
        chk("rst/rsp_dat", rsp_dat, 0);
        chk("rst/rsp_err", rsp_err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst/cyc", cyc, 0);
        chk("post_rst/rsp_valid", rsp_valid, 0);

        do_txn("write",     1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF, 2, 32'h0,         0);
        do_txn("read",      1'b0, 32'h3000_0000, 32'h0,         4'hF, 1, 32'hDEAD_BEEF, 0);
        do_txn("timeout",   1'b0, 32'h3000_0010, 32'h0,         4'hF, 0, 32'h0,         3);
        do_txn("ack_at_to", 1'b0, 32'h3000_0020, 32'h0,         4'hF, T, 32'hA5A5_A5A5, 0);
        do_txn("backpress", 1'b0, 32'h3000_0030, 32'h0,         4'h3, 3, 32'h0BAD_F00D, 5);

        // reset while the bus cycle is in flight
        cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("midrst/cyc_before", cyc, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst/cyc", cyc, 0);
        chk("midrst/stb", stb, 0);
        chk("midrst/rsp_valid", rsp_valid, 0);
        chk("midrst/cmd_ready", cmd_ready, 0);
        chk("midrst/adr", adr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst/no_rsp", rsp_valid, 0);
        do_txn("after_rst", 1'b0, 32'h3000_0044, 32'h0, 4'hF, 3, 32'hCAFE_0001, 1);

        for (int i = 0; i < 40; i++)
            do_txn("rand", 1'($urandom), $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(0, 10)), $urandom, int'($urandom_range(0, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
